snapshot_uploader: RTL and testbench
====================================

SNAPSHOT_UPLOADER -- requirements
Module: snapshot_uploader

Interface
REQ-001 SHALL have parameter RAM_BASE, default 23'h000000, SDRAM byte address of CPC RAM page 0.
REQ-002 SHALL have ports, clock and reset first:
- clk_sys  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- ram64k  in  1  1 = 64 KB model, 0 = 128 KB
- cpu_addr  in  16  CPU address, snooped during I/O writes
- io_wr  in  1  CPU I/O write strobe, level
- io_dout  in  8  CPU I/O write data
- ioctl_upload  in  1  HPS upload session active, level
- ioctl_rd  in  1  one-cycle byte request
- ioctl_addr  in  25  requested byte offset, valid with ioctl_rd
- ioctl_din  out  8  returned byte
- ioctl_wait  out  1  byte not yet ready
- mem_rd  out  1  SDRAM read request, level
- mem_addr  out  23  SDRAM byte address
- mem_din  in  8  SDRAM read data, valid when mem_ack=1
- mem_ack  in  1  one-cycle read completion

Function
REQ-003 Snoop: act only on io_wr rising edge (registered previous io_wr), and only while ioctl_upload=0.
REQ-004 Decode cpu_addr[15:8]:
- 7F, io_dout[7:6]=00: pen_sel<=io_dout[4:0]
- 7F, 01: pen[pen_sel[4]?16:pen_sel[3:0]]<=io_dout[4:0]
- 7F, 10: ga_mode<=io_dout
- 7F, 11: ram_cfg<=io_dout
- BC: crtc_sel<=io_dout[4:0]
- BD: crtc[crtc_sel]<=io_dout if crtc_sel<18, else ignored
- DF: upper_rom<=io_dout
REQ-005 Stream length L = 256 + (ram64k ? 65536 : 131072) bytes; offsets 0..255 header, 256..L-1 RAM.
REQ-006 Header: 0..7 ASCII "MV - SNA"; 0x10=8'h01; 0x2E=pen_sel; 0x2F..0x3F=pen[0..16]; 0x40=ga_mode; 0x41=ram_cfg; 0x42=crtc_sel; 0x43..0x54=crtc[0..17]; 0x55=upper_rom; 0x6B=8'h00; 0x6C=ram64k?8'h40:8'h80; all other bytes 8'h00.
REQ-007 States IDLE, HDR, MEM, OUT.
REQ-008 IDLE + ioctl_rd + ioctl_upload: next cycle ioctl_wait=1; offset<256 or offset>=L -> HDR; else -> MEM.
REQ-009 HDR: ioctl_din<=header byte (8'h00 if offset>=L), ioctl_wait<=0, -> IDLE; wait therefore high exactly 1 cycle.
REQ-010 MEM: mem_rd=1, mem_addr=RAM_BASE+(offset-256), 17-bit offset zero-extended, sum truncated to 23 bits; held stable until mem_ack.
REQ-011 mem_ack in MEM: mem_rd<=0, ioctl_din<=mem_din, -> OUT; OUT: ioctl_wait<=0, -> IDLE.
REQ-012 ioctl_rd outside IDLE SHALL be ignored; no queuing.
REQ-013 ioctl_rd with ioctl_upload=0 SHALL be ignored.
REQ-014 ioctl_upload falling in any state: next cycle -> IDLE, mem_rd=0, ioctl_wait=0; ioctl_din unchanged; late mem_ack discarded.
REQ-015 ram64k SHALL be sampled at each request; mid-session change affects later requests only.
REQ-016 Captured registers SHALL be frozen while ioctl_upload=1, so the header is consistent across a session.

Reset
REQ-017 reset: state IDLE; ioctl_wait=0, mem_rd=0, mem_addr=0, ioctl_din=0; pens, crtc, pen_sel, crtc_sel, ga_mode, ram_cfg, upper_rom =0; io_wr edge register=0.
REQ-018 reset SHALL override all inputs, including mid-MEM with mem_rd=1; mem_rd drops the next cycle.

Verification
REQ-019 Writes 7F00<-00, 7F00<-54, 7F00<-10, 7F00<-4B, BC00<-01, BD00<-28; read offsets 0x2F,0x3F,0x44 -> 14h,0Bh,28h, ioctl_wait high exactly 1 cycle each.
REQ-020 BC00<-1F then BD00<-AA -> all crtc header bytes unchanged; offset 0x42 -> 1Fh.
REQ-021 RAM_BASE=0, ram64k=0, read offset 256+0x1FFFF, mem_ack after 5 cycles with A5h -> mem_addr=01FFFFh, ioctl_din=A5h, wait low 2 cycles after ack.
REQ-022 ram64k=1, read offset 256+65536 -> no mem_rd, ioctl_din=00h; offset 0x6C -> 40h.
REQ-023 ioctl_upload dropped 2 cycles into MEM, then mem_ack -> mem_rd=0 and wait=0 next cycle, ioctl_din unchanged; a new request after re-raise completes normally.
REQ-024 I/O write 7F00<-8C during upload -> offset 0x40 unchanged; same write after upload ends -> 8Ch.

Source files
------------

// File: rtl/snapshot_uploader.sv
// Snoops CPC gate-array / CRTC / ROM-select I/O writes and streams a
// snapshot (256-byte header + RAM image from SDRAM) to the HPS upload port.
//
// Ports:
//   clk_sys, reset            clock, synchronous active-high reset
//   ram64k                    1 = 64 KB model, 0 = 128 KB
//   cpu_addr/io_wr/io_dout    CPU I/O write bus, snooped
//   ioctl_upload/rd/addr      HPS upload session, byte requests
//   ioctl_din/ioctl_wait      returned byte, not-ready flag
//   mem_rd/mem_addr           SDRAM read request and byte address
//   mem_din/mem_ack           SDRAM read data and one-cycle completion
module snapshot_uploader #(
  parameter logic [22:0] RAM_BASE = 23'h000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ram64k,
  input  logic [15:0] cpu_addr,
  input  logic        io_wr,
  input  logic [7:0]  io_dout,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        mem_rd,
  output logic [22:0] mem_addr,
  input  logic [7:0]  mem_din,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    MEM,
    OUT
  } state_e;

  state_e      state_q, state_d;
  logic        io_wr_q, io_wr_d;
  logic [4:0]  pen_q [17];
  logic [4:0]  pen_d [17];
  logic [7:0]  crtc_q [18];
  logic [7:0]  crtc_d [18];
  logic [4:0]  pen_sel_q, pen_sel_d;
  logic [4:0]  crtc_sel_q, crtc_sel_d;
  logic [7:0]  ga_mode_q, ga_mode_d;
  logic [7:0]  ram_cfg_q, ram_cfg_d;
  logic [7:0]  upper_rom_q, upper_rom_d;
  logic [24:0] offset_q, offset_d;
  logic        r64_q, r64_d;
  logic [7:0]  ioctl_din_q, ioctl_din_d;
  logic        ioctl_wait_q, ioctl_wait_d;
  logic        mem_rd_q, mem_rd_d;
  logic [22:0] mem_addr_q, mem_addr_d;

  // Only the high address byte selects the port.
  logic unused_addr_lo;
  assign unused_addr_lo = ^cpu_addr[7:0];

  logic wr_stb;
  assign wr_stb = io_wr & ~io_wr_q & ~ioctl_upload;

  logic is_ga, is_crtc_sel, is_crtc_dat, is_rom;
  assign is_ga       = cpu_addr[15:8] == 8'h7F;
  assign is_crtc_sel = cpu_addr[15:8] == 8'hBC;
  assign is_crtc_dat = cpu_addr[15:8] == 8'hBD;
  assign is_rom      = cpu_addr[15:8] == 8'hDF;

  logic [4:0] pen_idx;
  assign pen_idx = pen_sel_q[4] ? 5'd16 : {1'b0, pen_sel_q[3:0]};

  always_comb begin
    io_wr_d     = io_wr;
    pen_d       = pen_q;
    crtc_d      = crtc_q;
    pen_sel_d   = pen_sel_q;
    crtc_sel_d  = crtc_sel_q;
    ga_mode_d   = ga_mode_q;
    ram_cfg_d   = ram_cfg_q;
    upper_rom_d = upper_rom_q;
    if (wr_stb) begin
      unique case (1'b1)
        is_ga: begin
          unique case (io_dout[7:6])
            2'b00:   pen_sel_d = io_dout[4:0];
            2'b01:   pen_d[pen_idx] = io_dout[4:0];
            2'b10:   ga_mode_d = io_dout;
            default: ram_cfg_d = io_dout;
          endcase
        end
        is_crtc_sel: crtc_sel_d = io_dout[4:0];
        is_crtc_dat: begin
          if (crtc_sel_q < 5'd18)
            crtc_d[crtc_sel_q] = io_dout;
        end
        is_rom: upper_rom_d = io_dout;
        default: ;
      endcase
    end
  end

  // Header byte for the latched offset; indices wrap mod 32 but are
  // only used inside their guarded ranges.
  logic [7:0] off8;
  logic [4:0] pidx, cidx;
  logic [7:0] hdr_byte;
  assign off8 = offset_q[7:0];
  assign pidx = off8[4:0] - 5'h0F;
  assign cidx = off8[4:0] - 5'h03;

  always_comb begin
    hdr_byte = 8'h00;
    if (offset_q[24:8] == 17'd0) begin
      if (off8 >= 8'h2F && off8 <= 8'h3F)
        hdr_byte = {3'b000, pen_q[pidx]};
      else if (off8 >= 8'h43 && off8 <= 8'h54)
        hdr_byte = crtc_q[cidx];
      else begin
        case (off8)
          8'h00: hdr_byte = 8'h4D;
          8'h01: hdr_byte = 8'h56;
          8'h02: hdr_byte = 8'h20;
          8'h03: hdr_byte = 8'h2D;
          8'h04: hdr_byte = 8'h20;
          8'h05: hdr_byte = 8'h53;
          8'h06: hdr_byte = 8'h4E;
          8'h07: hdr_byte = 8'h41;
          8'h10: hdr_byte = 8'h01;
          8'h2E: hdr_byte = {3'b000, pen_sel_q};
          8'h40: hdr_byte = ga_mode_q;
          8'h41: hdr_byte = ram_cfg_q;
          8'h42: hdr_byte = {3'b000, crtc_sel_q};
          8'h55: hdr_byte = upper_rom_q;
          8'h6C: hdr_byte = r64_q ? 8'h40 : 8'h80;
          default: hdr_byte = 8'h00;
        endcase
      end
    end
  end

  logic [24:0] len;
  logic [16:0] ram_off;
  logic        in_ram;
  assign len     = ram64k ? 25'h0010100 : 25'h0020100;
  assign ram_off = ioctl_addr[16:0] - 17'd256;
  assign in_ram  = (ioctl_addr >= 25'd256) && (ioctl_addr < len);

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    r64_d        = r64_q;
    ioctl_din_d  = ioctl_din_q;
    ioctl_wait_d = ioctl_wait_q;
    mem_rd_d     = mem_rd_q;
    mem_addr_d   = mem_addr_q;
    if (!ioctl_upload) begin
      // Session ended: abandon any transfer, keep last byte.
      state_d      = IDLE;
      mem_rd_d     = 1'b0;
      ioctl_wait_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ioctl_rd) begin
            offset_d     = ioctl_addr;
            r64_d        = ram64k;
            ioctl_wait_d = 1'b1;
            if (in_ram) begin
              state_d    = MEM;
              mem_rd_d   = 1'b1;
              mem_addr_d = RAM_BASE + {6'd0, ram_off};
            end else begin
              state_d = HDR;
            end
          end
        end
        HDR: begin
          ioctl_din_d  = hdr_byte;
          ioctl_wait_d = 1'b0;
          state_d      = IDLE;
        end
        MEM: begin
          if (mem_ack) begin
            mem_rd_d    = 1'b0;
            ioctl_din_d = mem_din;
            state_d     = OUT;
          end
        end
        default: begin
          ioctl_wait_d = 1'b0;
          state_d      = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      io_wr_q      <= 1'b0;
      for (int i = 0; i < 17; i++) pen_q[i] <= 5'd0;
      for (int i = 0; i < 18; i++) crtc_q[i] <= 8'd0;
      pen_sel_q    <= 5'd0;
      crtc_sel_q   <= 5'd0;
      ga_mode_q    <= 8'd0;
      ram_cfg_q    <= 8'd0;
      upper_rom_q  <= 8'd0;
      offset_q     <= 25'd0;
      r64_q        <= 1'b0;
      ioctl_din_q  <= 8'd0;
      ioctl_wait_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= 23'd0;
    end else begin
      state_q      <= state_d;
      io_wr_q      <= io_wr_d;
      pen_q        <= pen_d;
      crtc_q       <= crtc_d;
      pen_sel_q    <= pen_sel_d;
      crtc_sel_q   <= crtc_sel_d;
      ga_mode_q    <= ga_mode_d;
      ram_cfg_q    <= ram_cfg_d;
      upper_rom_q  <= upper_rom_d;
      offset_q     <= offset_d;
      r64_q        <= r64_d;
      ioctl_din_q  <= ioctl_din_d;
      ioctl_wait_q <= ioctl_wait_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign ioctl_din  = ioctl_din_q;
  assign ioctl_wait = ioctl_wait_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_snapshot_uploader.sv
// Directed bench for snapshot_uploader: snooping, header, RAM stream,
// session abort and reset behaviour.
module tb_snapshot_uploader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ram64k = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        io_wr = 1'b0;
  logic [7:0]  io_dout = '0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_rd;
  logic [22:0] mem_addr;
  logic [7:0]  mem_din = '0;
  logic        mem_ack = 1'b0;

  int n_assert = 0;
  int n_fail = 0;

  snapshot_uploader #(.RAM_BASE(23'h000000)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ram64k(ram64k),
    .cpu_addr(cpu_addr),
    .io_wr(io_wr),
    .io_dout(io_dout),
    .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_ack(mem_ack)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    io_dout  = d;
    io_wr    = 1'b1;
    @(negedge clk_sys);
    io_wr = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic hread(input string tag, input logic [24:0] off,
                       input logic [7:0] exp);
    ioctl_addr = off;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    chk({tag, "_wait1"}, ioctl_wait, 1);
    chk({tag, "_nomem"}, mem_rd, 0);
    @(negedge clk_sys);
    chk({tag, "_wait0"}, ioctl_wait, 0);
    chk(tag, ioctl_din, exp);
  endtask

  task automatic mread(input string tag, input logic [24:0] off,
                       input logic [22:0] exp_addr, input int dly,
                       input logic [7:0] data);
    ioctl_addr = off;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    chk({tag, "_rd"}, mem_rd, 1);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    chk({tag, "_wait1"}, ioctl_wait, 1);
    repeat (dly - 1) @(negedge clk_sys);
    chk({tag, "_hold"}, mem_rd, 1);
    chk({tag, "_addr_hold"}, mem_addr, exp_addr);
    mem_ack = 1'b1;
    mem_din = data;
    @(negedge clk_sys);
    mem_ack = 1'b0;
    chk({tag, "_rd_drop"}, mem_rd, 0);
    chk({tag, "_wait_out"}, ioctl_wait, 1);
    chk({tag, "_din"}, ioctl_din, data);
    @(negedge clk_sys);
    chk({tag, "_wait0"}, ioctl_wait, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_sys);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_memrd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", ioctl_din, 0);
    reset = 1'b0;
    @(negedge clk_sys);

    io_write(16'h7F00, 8'h00);
    io_write(16'h7F00, 8'h54);
    io_write(16'h7F00, 8'h10);
    io_write(16'h7F00, 8'h4B);
    io_write(16'hBC00, 8'h01);
    io_write(16'hBD00, 8'h28);
    io_write(16'hDF00, 8'h07);
    io_write(16'h7F00, 8'hC5);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    hread("pen0", 25'h2F, 8'h14);
    hread("pen16", 25'h3F, 8'h0B);
    hread("crtc1", 25'h44, 8'h28);
    hread("sig0", 25'h00, 8'h4D);
    hread("sig7", 25'h07, 8'h41);
    hread("ver", 25'h10, 8'h01);
    hread("pensel", 25'h2E, 8'h10);
    hread("romsel", 25'h55, 8'h07);
    hread("ramcfg", 25'h41, 8'hC5);
    hread("pad", 25'h20, 8'h00);

    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    io_write(16'hBC00, 8'h1F);
    io_write(16'hBD00, 8'hAA);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    hread("crtcsel", 25'h42, 8'h1F);
    hread("crtc0_k", 25'h43, 8'h00);
    hread("crtc1_k", 25'h44, 8'h28);
    hread("crtc17_k", 25'h54, 8'h00);

    ram64k = 1'b0;
    mread("ram_last", 25'h200FF, 23'h01FFFF, 5, 8'hA5);

    ram64k = 1'b1;
    hread("r64_end", 25'h10100, 8'h00);
    hread("r64_size", 25'h6C, 8'h40);
    mread("r64_last", 25'h100FF, 23'h00FFFF, 2, 8'h3C);
    ram64k = 1'b0;
    hread("r128_end", 25'h20100, 8'h00);
    hread("r128_size", 25'h6C, 8'h80);

    ioctl_addr = 25'h1334;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    chk("abort_addr", mem_addr, 23'h001234);
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("abort_rd", mem_rd, 0);
    chk("abort_wait", ioctl_wait, 0);
    chk("abort_din", ioctl_din, 8'h80);
    mem_ack = 1'b1;
    mem_din = 8'h77;
    @(negedge clk_sys);
    mem_ack = 1'b0;
    chk("late_ack_din", ioctl_din, 8'h80);
    chk("late_ack_wait", ioctl_wait, 0);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    mread("reraise", 25'h100, 23'h000000, 1, 8'h5A);

    ioctl_addr = 25'h2F;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_addr = 25'h44;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    chk("busy_din", ioctl_din, 8'h14);
    chk("busy_wait", ioctl_wait, 0);
    @(negedge clk_sys);
    chk("busy_noq", ioctl_wait, 0);

    io_write(16'h7F00, 8'h8C);
    hread("frozen", 25'h40, 8'h00);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    ioctl_addr = 25'h41;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    chk("noup_wait", ioctl_wait, 0);
    @(negedge clk_sys);
    chk("noup_wait2", ioctl_wait, 0);
    chk("noup_din", ioctl_din, 8'h00);
    io_write(16'h7F00, 8'h8C);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    hread("gamode", 25'h40, 8'h8C);

    ioctl_addr = 25'h200;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    chk("rstm_rd", mem_rd, 1);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    chk("rstm_drop", mem_rd, 0);
    chk("rstm_wait", ioctl_wait, 0);
    chk("rstm_addr", mem_addr, 0);
    chk("rstm_din", ioctl_din, 0);
    hread("rstm_pen", 25'h2F, 8'h00);
    hread("rstm_ga", 25'h40, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
